// File: rtl/jk_step_conditioner.sv
// Push-button/switch conditioner for the JK lab flip-flop: synchronizes the raw
// inputs, debounces the button and issues one clock-enable pulse per accepted press.
module jk_step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int COUNT_WIDTH     = 20
) (
  input  logic       clockPulse,
  input  logic       reset,
  input  logic       rawButton,
  input  logic       rawJ,
  input  logic       rawK,
  output logic       stepPulse,
  output logic       J,
  output logic       K,
  output logic [7:0] pressCount,
  output logic [1:0] debug_state
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  state_t                 state, next_state;
  logic [COUNT_WIDTH-1:0] cnt, next_cnt;
  logic                   btn_m, btn_s, j_m, j_s, k_m, k_s;
  logic                   accept;

  // Two-flop synchronizers; only the second stage is used downstream.
  always_ff @(posedge clockPulse or posedge reset) begin
    if (reset) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      j_m   <= 1'b0;
      j_s   <= 1'b0;
      k_m   <= 1'b0;
      k_s   <= 1'b0;
    end else begin
      btn_m <= rawButton;
      btn_s <= btn_m;
      j_m   <= rawJ;
      j_s   <= j_m;
      k_m   <= rawK;
      k_s   <= k_m;
    end
  end

  always_ff @(posedge clockPulse or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          next_state = PRESS_WAIT;
          next_cnt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          next_state = IDLE;
        end else if (cnt == CNT_LAST) begin
          next_state = HELD;
          accept     = 1'b1;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          next_state = RELEASE_WAIT;
          next_cnt   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A high sample during release is bounce: fall back to HELD without a pulse.
        if (btn_s) begin
          next_state = HELD;
        end else if (cnt == CNT_LAST) begin
          next_state = IDLE;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // J/K and the press count change only on the accepting edge.
  always_ff @(posedge clockPulse or posedge reset) begin
    if (reset) begin
      stepPulse  <= 1'b0;
      J          <= 1'b0;
      K          <= 1'b0;
      pressCount <= 8'd0;
    end else begin
      stepPulse <= accept;
      if (accept) begin
        J          <= j_s;
        K          <= k_s;
        pressCount <= pressCount + 8'd1;
      end
    end
  end

  assign debug_state = state;

endmodule
